// File: rtl/rob_alloc_if.sv
// ROB allocator entry format and the dispatch / register-file port bundle.
// The package carries the entry layout shared by dispatch, the allocator and the ROB register file.
package rob_alloc_pkg;
   typedef struct packed {
      logic        valid;
      logic        spec_valid;
      logic        exception;
      logic [5:0]  dest_reg;
      logic [31:0] pc;
   } rob_rf_data;
endpackage

interface rob_alloc_if;
   import rob_alloc_pkg::*;

   logic       dispatch_valid;
   rob_rf_data dispatch_data;
   logic       dispatch_ready;
   logic [5:0] dispatch_tag;
   logic       wen_rf;
   logic [5:0] write_addr_rf;
   rob_rf_data write_data_rf;
   logic [5:0] rob_fifo_head;
   logic       rob_rf_retire_valid;
   logic       flush_req;
   logic [6:0] rob_count;
   logic       rob_empty;
   logic       rob_full;
   logic       flush_busy;

   // Dispatch / register-file side.
   modport master (
      output dispatch_valid, dispatch_data, rob_rf_retire_valid, flush_req,
      input  dispatch_ready, dispatch_tag, wen_rf, write_addr_rf, write_data_rf,
             rob_fifo_head, rob_count, rob_empty, rob_full, flush_busy
   );

   // Allocator side.
   modport slave (
      input  dispatch_valid, dispatch_data, rob_rf_retire_valid, flush_req,
      output dispatch_ready, dispatch_tag, wen_rf, write_addr_rf, write_data_rf,
             rob_fifo_head, rob_count, rob_empty, rob_full, flush_busy
   );
endinterface

// File: rtl/rob_alloc.sv
// ROB allocation and pointer manager for a 64-entry ROB register file.
// Owns head/tail/count, writes dispatched entries, and after a retire-time
// flush walks the abandoned entries invalidating one per cycle.
module rob_alloc
   import rob_alloc_pkg::*;
(
   input logic        clk,
   input logic        i_rst_n,
   rob_alloc_if.slave bus
);

   typedef enum logic {
      RUN,
      WALK
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] head_q, head_d;
   logic [5:0] tail_q, tail_d;
   logic [5:0] walk_ptr_q, walk_ptr_d;
   logic [5:0] walk_rem_q, walk_rem_d;
   logic [6:0] count_q, count_d;

   logic       full;
   logic       ready;
   logic       alloc;
   logic       retire;
   logic       flush;
   logic       wen;
   logic [5:0] waddr;
   rob_rf_data wdata;

   assign full = (count_q == 7'd64);

   // State, pointer and count registers.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= RUN;
         head_q     <= '0;
         tail_q     <= '0;
         walk_ptr_q <= '0;
         walk_rem_q <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         walk_ptr_q <= walk_ptr_d;
         walk_rem_q <= walk_rem_d;
         count_q    <= count_d;
      end
   end

   // Next-state, pointer updates and register-file write port.
   always_comb begin
      state_d    = state_q;
      head_d     = head_q;
      tail_d     = tail_q;
      walk_ptr_d = walk_ptr_q;
      walk_rem_d = walk_rem_q;
      count_d    = count_q;
      ready      = 1'b0;
      alloc      = 1'b0;
      retire     = 1'b0;
      flush      = 1'b0;
      wen        = 1'b0;
      waddr      = '0;
      wdata      = '0;

      unique case (state_q)
         RUN: begin
            ready  = !full && !bus.flush_req;
            alloc  = bus.dispatch_valid && ready;
            retire = bus.rob_rf_retire_valid;
            flush  = retire && bus.flush_req;
            if (flush) begin
               // Head jumps to the free tail slot; everything strictly
               // between the old head and tail is walked and zeroed.
               head_d     = tail_q;
               walk_ptr_d = head_q + 6'd1;
               walk_rem_d = 6'(count_q - 7'd1);
               count_d    = '0;
               state_d    = WALK;
            end else begin
               if (alloc) begin
                  wen              = 1'b1;
                  waddr            = tail_q;
                  wdata            = bus.dispatch_data;
                  wdata.valid      = 1'b1;
                  wdata.spec_valid = 1'b0;
                  tail_d           = tail_q + 6'd1;
               end
               head_d  = head_q + {5'b0, retire};
               count_d = count_q + {6'b0, alloc} - {6'b0, retire};
            end
         end
         WALK: begin
            if (walk_rem_q != 6'd0) begin
               wen        = 1'b1;
               waddr      = walk_ptr_q;
               walk_ptr_d = walk_ptr_q + 6'd1;
               walk_rem_d = walk_rem_q - 6'd1;
            end else begin
               state_d = RUN;
            end
         end
      endcase
   end

   assign bus.dispatch_ready = ready;
   assign bus.dispatch_tag   = tail_q;
   assign bus.wen_rf         = wen;
   assign bus.write_addr_rf  = waddr;
   assign bus.write_data_rf  = wdata;
   assign bus.rob_fifo_head  = head_q;
   assign bus.rob_count      = count_q;
   assign bus.rob_empty      = (count_q == 7'd0);
   assign bus.rob_full       = full;
   assign bus.flush_busy     = (state_q == WALK);

endmodule
